// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the instruction-fetch stage: FSM states and fetch constants.
package cpu_pkg;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam int unsigned INSTR_BYTES      = 4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus: fetch side is master, memory is slave.
interface fetch_unit_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);

  logic                  imem_req;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic                  imem_rvalid;
  logic [DATA_WIDTH-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rvalid,
    output imem_rdata
  );

endinterface

// File: rtl/fetch_unit_if_id_reg.sv
// IF/ID pipeline register: captures a fetched word with its PC, cleared by consume or flush.
module if_id_reg
  import cpu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_load,
  input  logic                  i_consume,
  input  logic                  i_flush,
  input  logic [DATA_WIDTH-1:0] i_instr,
  input  logic [ADDR_WIDTH-1:0] i_pc,
  output logic [DATA_WIDTH-1:0] o_instr,
  output logic [ADDR_WIDTH-1:0] o_pc,
  output logic [ADDR_WIDTH-1:0] o_pc_plus4,
  output logic                  o_valid
);

  // Flush outranks load, and a load in the same cycle as consumption keeps the register live.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_instr    <= DATA_WIDTH'(NOP_INSTR);
      o_pc       <= '0;
      o_pc_plus4 <= '0;
      o_valid    <= 1'b0;
    end else if (i_flush) begin
      o_instr <= DATA_WIDTH'(NOP_INSTR);
      o_valid <= 1'b0;
    end else if (i_load) begin
      o_instr    <= i_instr;
      o_pc       <= i_pc;
      o_pc_plus4 <= i_pc + ADDR_WIDTH'(INSTR_BYTES);
      o_valid    <= 1'b1;
    end else if (i_consume) begin
      o_valid <= 1'b0;
    end else begin
      o_valid <= o_valid;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, keeps one memory request in flight and
// fills the IF/ID register, discarding a response made stale by a redirect.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(RESET_PC_DEFAULT)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  fetch_unit_if.master          imem,
  input  logic                  i_stall,
  input  logic                  i_redirect,
  input  logic [ADDR_WIDTH-1:0] i_redirect_target,
  output logic [DATA_WIDTH-1:0] o_instr,
  output logic [ADDR_WIDTH-1:0] o_pc,
  output logic [ADDR_WIDTH-1:0] o_pc_plus4,
  output logic                  o_instr_valid
);

  fetch_state_t          r_state;
  fetch_state_t          w_state_next;
  logic [ADDR_WIDTH-1:0] r_pc_q;
  logic [ADDR_WIDTH-1:0] w_pc_next;
  logic [ADDR_WIDTH-1:0] w_target_aligned;
  logic                  w_free;
  logic                  w_req;
  logic                  w_capture;
  logic                  w_consume;

  assign w_target_aligned = i_redirect_target & ~ADDR_WIDTH'(INSTR_BYTES - 1);
  assign w_free           = !o_instr_valid || !i_stall;
  assign w_req            = (r_state == REQ) && w_free && !i_rst && !i_redirect;
  assign w_capture        = (r_state == WAIT) && imem.imem_rvalid && !i_redirect && !i_rst;
  assign w_consume        = o_instr_valid && !i_stall;

  assign imem.imem_req  = w_req;
  assign imem.imem_addr = r_pc_q;

  // Next-state and next-PC decode; redirect overrides the normal flow in every state.
  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc_q;
    if (i_redirect) begin
      w_pc_next = w_target_aligned;
      case (r_state)
        REQ:     w_state_next = REQ;
        WAIT:    w_state_next = imem.imem_rvalid ? REQ : DROP;
        DROP:    w_state_next = DROP;
        default: w_state_next = REQ;
      endcase
    end else begin
      case (r_state)
        REQ: begin
          if (w_req) begin
            w_state_next = WAIT;
          end else begin
            w_state_next = REQ;
          end
        end
        WAIT: begin
          if (imem.imem_rvalid) begin
            w_state_next = REQ;
            w_pc_next    = r_pc_q + ADDR_WIDTH'(INSTR_BYTES);
          end else begin
            w_state_next = WAIT;
          end
        end
        DROP: begin
          if (imem.imem_rvalid) begin
            w_state_next = REQ;
          end else begin
            w_state_next = DROP;
          end
        end
        default: w_state_next = REQ;
      endcase
    end
  end

  // FSM state and fetch PC registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= REQ;
      r_pc_q  <= RESET_PC;
    end else begin
      r_state <= w_state_next;
      r_pc_q  <= w_pc_next;
    end
  end

  if_id_reg #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_if_id_reg (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (w_capture),
    .i_consume  (w_consume),
    .i_flush    (i_redirect),
    .i_instr    (imem.imem_rdata),
    .i_pc       (r_pc_q),
    .o_instr    (o_instr),
    .o_pc       (o_pc),
    .o_pc_plus4 (o_pc_plus4),
    .o_valid    (o_instr_valid)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: two instances (default and wrapping RESET_PC) driven by
// behavioural instruction memories with programmable response latency.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_target;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        instr_valid;

  logic        stall2;
  logic        redirect2;
  logic [31:0] redirect_target2;
  logic [31:0] instr2;
  logic [31:0] pc2;
  logic [31:0] pc_plus4_2;
  logic        instr_valid2;

  int n_checks;
  int n_fail;

  // memory model state for instance 0 (programmable latency) and instance 1 (fixed 1 cycle)
  int          mem_lat;
  int          mem_cnt;
  logic        mem_pending;
  logic [31:0] mem_paddr;
  logic        req_seen;
  logic [31:0] addr_seen;
  logic        req2_seen;
  logic [31:0] addr2_seen;

  fetch_unit_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) imem0 ();
  fetch_unit_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) imem1 ();

  fetch_unit #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (32),
    .RESET_PC   (32'h0000_0000)
  ) dut (
    .i_clk             (clk),
    .i_rst             (rst),
    .imem              (imem0),
    .i_stall           (stall),
    .i_redirect        (redirect),
    .i_redirect_target (redirect_target),
    .o_instr           (instr),
    .o_pc              (pc),
    .o_pc_plus4        (pc_plus4),
    .o_instr_valid     (instr_valid)
  );

  fetch_unit #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (32),
    .RESET_PC   (32'hFFFF_FFFC)
  ) dut_wrap (
    .i_clk             (clk),
    .i_rst             (rst),
    .imem              (imem1),
    .i_stall           (stall2),
    .i_redirect        (redirect2),
    .i_redirect_target (redirect_target2),
    .o_instr           (instr2),
    .o_pc              (pc2),
    .o_pc_plus4        (pc_plus4_2),
    .o_instr_valid     (instr_valid2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    if (addr == 32'h0000_0000) begin
      return 32'h0050_0093;
    end else begin
      return addr ^ 32'h1234_0000;
    end
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (obs !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // one clock: sample requests just before the edge, then update both memory models
  task automatic tick();
    #1;
    req_seen   = imem0.imem_req;
    addr_seen  = imem0.imem_addr;
    req2_seen  = imem1.imem_req;
    addr2_seen = imem1.imem_addr;
    @(posedge clk);
    #1;
    imem0.imem_rvalid = 1'b0;
    if (req_seen) begin
      mem_pending = 1'b1;
      mem_cnt     = mem_lat;
      mem_paddr   = addr_seen;
    end
    if (mem_pending) begin
      if (mem_cnt <= 1) begin
        imem0.imem_rvalid = 1'b1;
        imem0.imem_rdata  = mem_word(mem_paddr);
        mem_pending       = 1'b0;
      end else begin
        mem_cnt = mem_cnt - 1;
      end
    end
    imem1.imem_rvalid = req2_seen;
    imem1.imem_rdata  = mem_word(addr2_seen);
  endtask

  initial begin
    n_checks          = 0;
    n_fail            = 0;
    mem_lat           = 1;
    mem_cnt           = 0;
    mem_pending       = 1'b0;
    mem_paddr         = 32'h0;
    rst               = 1'b1;
    stall             = 1'b0;
    redirect          = 1'b0;
    redirect_target   = 32'h0;
    stall2            = 1'b0;
    redirect2         = 1'b0;
    redirect_target2  = 32'h0;
    imem0.imem_rvalid = 1'b0;
    imem0.imem_rdata  = 32'h0;
    imem1.imem_rvalid = 1'b0;
    imem1.imem_rdata  = 32'h0;

    tick();
    tick();
    check_eq("rst_valid", {31'd0, instr_valid}, 32'd0);
    check_eq("rst_instr", instr, NOP);
    check_eq("rst_pc", pc, 32'h0);
    check_eq("rst_pc4", pc_plus4, 32'h0);
    check_eq("rst_req", {31'd0, imem0.imem_req}, 32'd0);

    // first fetch with 1-cycle memory
    rst = 1'b0;
    #1;
    check_eq("first_req", {31'd0, imem0.imem_req}, 32'd1);
    check_eq("first_addr", imem0.imem_addr, 32'h0);
    check_eq("wrap_first_addr", imem1.imem_addr, 32'hFFFF_FFFC);
    tick();
    check_eq("wait_valid", {31'd0, instr_valid}, 32'd0);
    check_eq("wait_req", {31'd0, imem0.imem_req}, 32'd0);
    tick();
    check_eq("cap_instr", instr, 32'h0050_0093);
    check_eq("cap_pc", pc, 32'h0);
    check_eq("cap_pc4", pc_plus4, 32'h4);
    check_eq("cap_valid", {31'd0, instr_valid}, 32'd1);
    check_eq("next_addr", imem0.imem_addr, 32'h4);
    check_eq("wrap_pc", pc2, 32'hFFFF_FFFC);
    check_eq("wrap_pc4", pc_plus4_2, 32'h0);
    check_eq("wrap_instr", instr2, 32'hEDCB_FFFC);
    check_eq("wrap_next_addr", imem1.imem_addr, 32'h0);

    // stall held five cycles
    stall = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      check_eq("stall_req", {31'd0, imem0.imem_req}, 32'd0);
      check_eq("stall_instr", instr, 32'h0050_0093);
      check_eq("stall_valid", {31'd0, instr_valid}, 32'd1);
      tick();
    end
    stall = 1'b0;
    #1;
    check_eq("unstall_req", {31'd0, imem0.imem_req}, 32'd1);
    check_eq("unstall_addr", imem0.imem_addr, 32'h4);
    tick();
    check_eq("consumed_valid", {31'd0, instr_valid}, 32'd0);
    tick();
    check_eq("cap4_instr", instr, 32'h1234_0004);
    check_eq("cap4_pc", pc, 32'h4);

    // redirect while waiting on a 3-cycle response
    mem_lat = 3;
    check_eq("req8_addr", imem0.imem_addr, 32'h8);
    tick();
    redirect        = 1'b1;
    redirect_target = 32'h0000_0100;
    #1;
    check_eq("redir_req", {31'd0, imem0.imem_req}, 32'd0);
    tick();
    redirect = 1'b0;
    #1;
    check_eq("drop_valid", {31'd0, instr_valid}, 32'd0);
    check_eq("drop_instr", instr, NOP);
    check_eq("drop_req", {31'd0, imem0.imem_req}, 32'd0);
    tick();
    check_eq("stale_rvalid_req", {31'd0, imem0.imem_req}, 32'd0);
    tick();
    check_eq("after_drop_valid", {31'd0, instr_valid}, 32'd0);
    check_eq("after_drop_req", {31'd0, imem0.imem_req}, 32'd1);
    check_eq("after_drop_addr", imem0.imem_addr, 32'h100);
    mem_lat = 1;
    tick();
    tick();
    check_eq("tgt_pc", pc, 32'h100);
    check_eq("tgt_instr", instr, 32'h1234_0100);
    check_eq("tgt_pc4", pc_plus4, 32'h104);

    // redirect coinciding with rvalid
    tick();
    check_eq("coinc_rvalid", {31'd0, imem0.imem_rvalid}, 32'd1);
    redirect        = 1'b1;
    redirect_target = 32'h0000_0040;
    tick();
    redirect = 1'b0;
    #1;
    check_eq("coinc_valid", {31'd0, instr_valid}, 32'd0);
    check_eq("coinc_instr", instr, NOP);
    check_eq("coinc_req", {31'd0, imem0.imem_req}, 32'd1);
    check_eq("coinc_addr", imem0.imem_addr, 32'h40);

    // redirect to a misaligned target under stall
    tick();
    tick();
    check_eq("cap40_valid", {31'd0, instr_valid}, 32'd1);
    stall           = 1'b1;
    redirect        = 1'b1;
    redirect_target = 32'h0000_0203;
    #1;
    check_eq("stall_redir_req", {31'd0, imem0.imem_req}, 32'd0);
    tick();
    redirect = 1'b0;
    #1;
    check_eq("flush_valid", {31'd0, instr_valid}, 32'd0);
    check_eq("flush_instr", instr, NOP);
    check_eq("flush_req", {31'd0, imem0.imem_req}, 32'd1);
    check_eq("flush_addr", imem0.imem_addr, 32'h200);
    stall = 1'b0;

    // reset asserted mid-WAIT
    tick();
    rst = 1'b1;
    #1;
    check_eq("rst_mid_req", {31'd0, imem0.imem_req}, 32'd0);
    tick();
    check_eq("rst_mid_valid", {31'd0, instr_valid}, 32'd0);
    check_eq("rst_mid_instr", instr, NOP);
    check_eq("rst_mid_pc", pc, 32'h0);
    rst = 1'b0;
    #1;
    check_eq("rerst_req", {31'd0, imem0.imem_req}, 32'd1);
    check_eq("rerst_addr", imem0.imem_addr, 32'h0);
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
